// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light reaction timer.
package f1_pkg;

  localparam int RT_W_DEFAULT = 16;

  localparam logic [7:0] LIGHTS_ALL = 8'hFF;
  localparam logic [7:0] LIGHTS_OFF = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_TIMING = 3'd2,
    S_DONE   = 3'd3,
    S_FAULT  = 3'd4
  } f1_state_e;

endpackage

// File: rtl/f1_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 and pulses o_tick on the last count.
// Held at zero while i_clear is high.
module f1_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == LAST);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear || w_at_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = w_at_last & ~i_clear;

endmodule

// File: rtl/f1_reaction_timer.sv
// Measures driver reaction time from lights-out to button press, in prescaled ticks.
// Optional false-start detection is enabled by defining F1_JUMPSTART_DETECT_EN.
module f1_reaction_timer
  import f1_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int RT_W     = RT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      lights,
  input  logic            trigger,
  output logic [RT_W-1:0] rt_ms,
  output logic            rt_valid,
  input  logic            rt_ready,
  output logic            busy,
  output logic            jump_start
);

  f1_state_e       r_state;
  f1_state_e       w_state_nxt;
  logic            r_trig_d;
  logic            w_press;
  logic            w_tick;
  logic            w_presc_clr;
  logic [RT_W-1:0] r_count;
  logic [RT_W-1:0] r_rt_ms;

  // The edge register runs in every state, so a button already held on entry
  // to TIMING never looks like a fresh press.
  assign w_press     = trigger & ~r_trig_d;
  assign w_presc_clr = (r_state != S_TIMING);

  f1_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_presc_clr),
    .o_tick (w_tick)
  );

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (lights == LIGHTS_ALL) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
`ifdef F1_JUMPSTART_DETECT_EN
        if (w_press)                   w_state_nxt = S_FAULT;
        else if (lights == LIGHTS_OFF) w_state_nxt = S_TIMING;
        else if (lights != LIGHTS_ALL) w_state_nxt = S_IDLE;
`else
        if (lights == LIGHTS_OFF)      w_state_nxt = S_TIMING;
        else if (lights != LIGHTS_ALL) w_state_nxt = S_IDLE;
`endif
      end
      S_TIMING: begin
        if (w_press) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (rt_ready) w_state_nxt = S_IDLE;
      end
`ifdef F1_JUMPSTART_DETECT_EN
      S_FAULT: begin
        if (lights == LIGHTS_OFF) w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_trig_d <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_trig_d <= trigger;
    end
  end

  // Counter is held at zero outside TIMING; a press beats a coincident tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (r_state != S_TIMING) begin
      r_count <= '0;
    end else if (w_tick && !w_press && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rt_ms <= '0;
    end else if (r_state == S_TIMING && w_press) begin
      r_rt_ms <= r_count;
    end
  end

`ifdef F1_JUMPSTART_DETECT_EN
  logic r_jump_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_jump_start <= 1'b0;
    end else if (r_state == S_IDLE && w_state_nxt == S_ARMED) begin
      r_jump_start <= 1'b0;
    end else if (r_state == S_ARMED && w_state_nxt == S_FAULT) begin
      r_jump_start <= 1'b1;
    end
  end

  assign jump_start = r_jump_start;
`else
  assign jump_start = 1'b0;
`endif

  assign rt_ms    = r_rt_ms;
  assign rt_valid = (r_state == S_DONE);
  assign busy     = (r_state == S_ARMED) || (r_state == S_TIMING);

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Scoreboard bench for f1_reaction_timer: a 16-bit and a 4-bit instance share stimulus.
module tb_f1_reaction_timer;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  lights = 8'h00;
  logic        trigger = 1'b0;
  logic        rt_ready = 1'b0;

  logic [15:0] rt_ms;
  logic        rt_valid, busy, jump_start;
  logic [3:0]  rt_ms_n;
  logic        rt_valid_n, busy_n, jump_start_n;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  f1_reaction_timer #(.TICK_DIV(TD), .RT_W(16)) dut (
    .clk(clk), .rst(rst), .lights(lights), .trigger(trigger),
    .rt_ms(rt_ms), .rt_valid(rt_valid), .rt_ready(rt_ready),
    .busy(busy), .jump_start(jump_start)
  );

  f1_reaction_timer #(.TICK_DIV(TD), .RT_W(4)) dut_n (
    .clk(clk), .rst(rst), .lights(lights), .trigger(trigger),
    .rt_ms(rt_ms_n), .rt_valid(rt_valid_n), .rt_ready(rt_ready),
    .busy(busy_n), .jump_start(jump_start_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Starts in TIMING cycle 1; drives a press so it is sampled at the end of press_cycle.
  task automatic run_timing(input int press_cycle, input bit hold, input int release_cycle,
                            input bit scramble);
    exp_q.push_back((press_cycle - 1) / TD);
    check("busy_timing", busy, 1);
    for (int c = 2; c <= press_cycle; c++) begin
      step();
      if (scramble) lights = 8'($urandom);
      if (hold && c == release_cycle) trigger = 1'b0;
      if (c == press_cycle) trigger = 1'b1;
    end
    step();
    trigger = 1'b0;
    lights  = 8'h00;
  endtask

  task automatic measure(input int press_cycle, input bit hold, input int release_cycle,
                         input bit scramble);
    if (hold) begin
      trigger = 1'b1;
      step();
    end
    lights = 8'hFF;
    step();
    check("busy_armed", busy, 1);
    lights = 8'h00;
    step();
    run_timing(press_cycle, hold, release_cycle, scramble);
  endtask

  task automatic collect();
    int n = 0;
    int e;
    logic [15:0] held;
    while (!rt_valid && n < 200) begin
      step();
      n++;
    end
    check("rt_valid_seen", rt_valid, 1);
    check("rt_valid_seen_n", rt_valid_n, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rt_ms", rt_ms, sat(e, 16'hFFFF));
      check("rt_ms_n", rt_ms_n, sat(e, 15));
    end
    check("busy_done", busy, 0);
    step();
    check("rt_valid_hold", rt_valid, 1);
    held = rt_ms;
    rt_ready = 1'b1;
    step();
    rt_ready = 1'b0;
    check("rt_valid_after_hs", rt_valid, 0);
    check("busy_after_hs", busy, 0);
    check("rt_ms_held", rt_ms, held);
    lights = 8'hFF;
    step();
    check("rearm_from_idle", busy, 1);
    lights = 8'h12;
    step();
    lights = 8'h00;
    check("abort_after_rearm", busy, 0);
  endtask

  initial begin
    #12;
    check("rst_rt_ms", rt_ms, 0);
    check("rst_rt_valid", rt_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_jump", jump_start, 0);
    rst = 1'b1;
    step();

    // Basic measurement and tick/press coincidence
    measure(42, 0, 0, 0);
    collect();
    measure(40, 0, 0, 0);
    collect();

    // Button held across lights-out, released, pressed again
    measure(22, 1, 5, 0);
    collect();

    // Lights changes during TIMING must not matter
    measure(30, 0, 0, 1);
    collect();

    // Saturation on the 4-bit instance
    measure(80, 0, 0, 0);
    collect();

    // Press in ARMED
    lights = 8'hFF;
    step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
`ifdef F1_JUMPSTART_DETECT_EN
    check("js_set", jump_start, 1);
    check("js_busy", busy, 0);
    step();
    check("js_fault_hold", jump_start, 1);
    check("js_no_valid", rt_valid, 0);
    lights = 8'h00;
    step();
    check("js_sticky_idle", jump_start, 1);
    check("js_idle_busy", busy, 0);
    lights = 8'hFF;
    step();
    check("js_cleared", jump_start, 0);
    check("js_rearmed", busy, 1);
    lights = 8'h7F;
    step();
    lights = 8'h00;
    check("js_abort", busy, 0);
`else
    check("js_off", jump_start, 0);
    check("js_off_armed", busy, 1);
    lights = 8'h00;
    step();
    run_timing(13, 0, 0, 0);
    collect();
`endif

    // Abort from ARMED
    lights = 8'hFF;
    step();
    check("abort_armed", busy, 1);
    lights = 8'h7F;
    step();
    lights = 8'h00;
    check("abort_busy", busy, 0);
    check("abort_valid", rt_valid, 0);
    step();
    check("abort_stays_idle", busy, 0);

    // Reset mid-TIMING
    lights = 8'hFF;
    step();
    lights = 8'h00;
    step();
    repeat (9) step();
    #2 rst = 1'b0;
    #1;
    check("rst_timing_busy", busy, 0);
    check("rst_timing_valid", rt_valid, 0);
    check("rst_timing_ms", rt_ms, 0);
    #2 rst = 1'b1;
    step();

    // Reset mid-DONE discards the result
    measure(25, 0, 0, 0);
    check("pre_rst_valid", rt_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("rst_done_valid", rt_valid, 0);
    check("rst_done_ms", rt_ms, 0);
    check("rst_done_jump", jump_start, 0);
    void'(exp_q.pop_front());
    #2 rst = 1'b1;
    step();

    measure(9, 0, 0, 0);
    collect();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
